// File: rtl/rv_pkg.sv
// Shared writeback definitions: register-file geometry and the queue entry
// layout used by wb_write_queue and wb_match.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;

  typedef struct packed {
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Pending-write lookup for one decode query address.
// Walks the queue from head (oldest) towards tail (youngest); a younger
// match overrides an older one, so the result is the youngest matching entry.
//
// Ports:
//   entries  queue storage, indexed by slot
//   valid    per-slot occupancy mask
//   head     slot index of the oldest entry
//   rs       query register address (x0 never hits)
//   hit      a valid entry targets rs
//   data     data of the youngest matching entry, 0 when no hit
module wb_match
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      valid,
  input  logic [PW-1:0]         head,
  input  logic [RAW-1:0]        rs,
  output logic                  hit,
  output logic [XLEN-1:0]       data
);

  logic [PW-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && (rs != '0) && (entries[idx].rd == rs)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Writeback queue feeding the register file write port (a3/we3/wd3).
// Two producers (A = ALU, B = load unit) enqueue in order, A before B when
// both are accepted together; one entry retires per cycle while non-empty.
// Beats to x0 are consumed but never stored.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   a_valid/a_ready/a_rd/a_data   ALU result handshake
//   b_valid/b_ready/b_rd/b_data   load result handshake
//   we3, a3, wd3          register file write port (head entry)
//   q1_rs/q1_hit/q1_data  decode query 1
//   q2_rs/q2_hit/q2_data  decode query 2
//   count                 current occupancy, 0..DEPTH
//
// Build option: WB_BYPASS_EN -- when defined, q*_data forwards the youngest
// pending data for the queried register; otherwise q*_data is tied to 0.
module wb_write_queue
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = rv_pkg::XLEN,
  parameter int unsigned RAW   = rv_pkg::RAW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [RAW-1:0]           a_rd,
  input  logic [XLEN-1:0]          a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [RAW-1:0]           b_rd,
  input  logic [XLEN-1:0]          b_data,
  output logic                     we3,
  output logic [RAW-1:0]           a3,
  output logic [XLEN-1:0]          wd3,
  input  logic [RAW-1:0]           q1_rs,
  input  logic [RAW-1:0]           q2_rs,
  output logic                     q1_hit,
  output logic                     q2_hit,
  output logic [XLEN-1:0]          q1_data,
  output logic [XLEN-1:0]          q2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  pop, a_push, b_push;
  logic [PW-1:0]         b_slot;
  logic [PW-1:0]         offs;
  logic [DEPTH-1:0]      valid;
  logic                  m1_hit, m2_hit;
  logic [XLEN-1:0]       m1_data, m2_data;

  // Handshake: ready ignores the same-cycle pop; B only sees the slot A
  // actually consumes (an x0 beat on A does not take a slot).
  always_comb begin
    pop     = (count_q != '0);
    a_ready = (count_q < DEPTH_C);
    a_push  = a_valid && a_ready && (a_rd != '0);
    b_ready = ((count_q + CW'(a_push)) < DEPTH_C);
    b_push  = b_valid && b_ready && (b_rd != '0);
  end

  // Occupancy mask from head/count: slot i is live when its distance from
  // head (mod DEPTH) is below count.
  always_comb begin
    valid = '0;
    offs  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs     = PW'(i) - head_q;
      valid[i] = ({1'b0, offs} < count_q);
    end
  end

  always_comb begin
    entries_d = entries_q;
    b_slot    = tail_q + PW'(a_push);
    if (a_push) begin
      entries_d[tail_q].rd   = a_rd;
      entries_d[tail_q].data = a_data;
    end
    if (b_push) begin
      entries_d[b_slot].rd   = b_rd;
      entries_d[b_slot].data = b_data;
    end
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(a_push) + PW'(b_push);
    count_d = count_q - CW'(pop) + CW'(a_push) + CW'(b_push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    we3   = pop;
    a3    = pop ? entries_q[head_q].rd   : '0;
    wd3   = pop ? entries_q[head_q].data : '0;
    count = count_q;
  end

  wb_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (entries_q),
    .valid   (valid),
    .head    (head_q),
    .rs      (q1_rs),
    .hit     (m1_hit),
    .data    (m1_data)
  );

  wb_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (entries_q),
    .valid   (valid),
    .head    (head_q),
    .rs      (q2_rs),
    .hit     (m2_hit),
    .data    (m2_data)
  );

  assign q1_hit = m1_hit;
  assign q2_hit = m2_hit;

`ifdef WB_BYPASS_EN
  assign q1_data = m1_data;
  assign q2_data = m2_data;
`else
  logic unused_fwd;
  assign q1_data    = '0;
  assign q2_data    = '0;
  assign unused_fwd = ^{m1_data, m2_data};
`endif

endmodule
